// File: rtl/muladd_mult.sv
// muladd_mult: gated two-operand adder plus a signed multiplier.
//
// Sum    = (EnA ? A : 0) + (EnB ? B : 0), modulo 2^WIDTH.
// Prod2x = exact signed A*B (2*WIDTH bits), Prod = Prod2x[WIDTH-1:0].
//
// The product is built from explicit sign-extended partial products that are
// accumulated with ripple-carry adders. The row for B's sign bit carries a
// negative weight, so it is subtracted (added in two's complement) rather
// than added.
//
// Build option:
//   MULADD_MULT_OUTREG_EN  defined   -> outputs registered on rising Clock,
//                                       1-cycle latency, async clear on nReset.
//   MULADD_MULT_OUTREG_EN  undefined -> purely combinational, Clock and nReset
//                                       are ignored (tying both low is legal).
module muladd_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 EnA,
  input  logic                 EnB,
  output logic [WIDTH-1:0]     Sum,
  output logic [WIDTH-1:0]     Prod,
  output logic [2*WIDTH-1:0]   Prod2x
);

  localparam int PW = 2 * WIDTH;

  // ---------------------------------------------------------------------------
  // Adder helpers: bit-level ripple-carry adders built from full-adder cells.
  // ---------------------------------------------------------------------------

  // WIDTH-bit ripple-carry adder; the final carry is dropped so the result wraps.
  function automatic logic [WIDTH-1:0] add_w(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic             c;
    logic [WIDTH-1:0] s;
    c = 1'b0;
    s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return s;
  endfunction

  // 2*WIDTH-bit ripple-carry adder with carry-in (carry-in = 1 with an
  // inverted operand performs subtraction).
  function automatic logic [PW-1:0] add_p(
    input logic [PW-1:0] x,
    input logic [PW-1:0] y,
    input logic          cin
  );
    logic          c;
    logic [PW-1:0] s;
    c = cin;
    s = {PW{1'b0}};
    for (int i = 0; i < PW; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Gated adder path
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] term_a_s;
  logic [WIDTH-1:0] term_b_s;
  logic [WIDTH-1:0] sum_s;

  // Gate each operand into the adder; a disabled term contributes zero.
  always_comb begin
    term_a_s = {WIDTH{1'b0}};
    term_b_s = {WIDTH{1'b0}};
    if (EnA) begin
      term_a_s = A;
    end else begin
      term_a_s = {WIDTH{1'b0}};
    end
    if (EnB) begin
      term_b_s = B;
    end else begin
      term_b_s = {WIDTH{1'b0}};
    end
  end

  assign sum_s = add_w(term_a_s, term_b_s);

  // ---------------------------------------------------------------------------
  // Signed multiplier path (independent of EnA/EnB)
  // ---------------------------------------------------------------------------
  logic [PW-1:0] a_ext_s;
  logic [PW-1:0] pp_s [WIDTH];
  logic [PW-1:0] prod_s;

  // A sign-extended to the full product width so every row is already signed.
  assign a_ext_s = {{WIDTH{A[WIDTH-1]}}, A};

  // One partial-product row per bit of B: shifted A when the bit is set.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
    assign pp_s[gi] = B[gi] ? (a_ext_s << gi) : {PW{1'b0}};
  end

  // Accumulate the rows; B's MSB row has weight -2^(WIDTH-1) and is subtracted.
  always_comb begin
    logic [PW-1:0] acc;
    acc = {PW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) begin
        acc = add_p(acc, ~pp_s[i], 1'b1);
      end else begin
        acc = add_p(acc, pp_s[i], 1'b0);
      end
    end
    prod_s = acc;
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
`ifdef MULADD_MULT_OUTREG_EN

  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] prod_r;
  logic [PW-1:0]    prod2x_r;

  // Output registers: async clear drops any pending result, else capture.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sum_r    <= {WIDTH{1'b0}};
      prod_r   <= {WIDTH{1'b0}};
      prod2x_r <= {PW{1'b0}};
    end else begin
      sum_r    <= sum_s;
      prod_r   <= prod_s[WIDTH-1:0];
      prod2x_r <= prod_s;
    end
  end

  assign Sum    = sum_r;
  assign Prod   = prod_r;
  assign Prod2x = prod2x_r;

`else

  // Clock and reset are not used by the combinational build.
  logic unused_clk_rst_s;
  assign unused_clk_rst_s = Clock ^ nReset;

  assign Sum    = sum_s;
  assign Prod   = prod_s[WIDTH-1:0];
  assign Prod2x = prod_s;

`endif

endmodule

// File: tb/tb_muladd_mult.sv
// Scoreboard testbench for muladd_mult (WIDTH=8). Works for both builds:
// latency is 0 in the combinational build and 1 with MULADD_MULT_OUTREG_EN.
module tb_muladd_mult;

`ifdef MULADD_MULT_OUTREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        Clock;
  logic        nReset;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        EnA;
  logic        EnB;
  logic [7:0]  Sum;
  logic [7:0]  Prod;
  logic [15:0] Prod2x;

  typedef struct {
    string       name;
    logic [7:0]  s;
    logic [7:0]  p;
    logic [15:0] p2;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  muladd_mult #(.WIDTH(8)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .A      (A),
    .B      (B),
    .EnA    (EnA),
    .EnB    (EnB),
    .Sum    (Sum),
    .Prod   (Prod),
    .Prod2x (Prod2x)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // cycle counter used to time scoreboard entries
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor: pop entries as they fall due and compare against DUT outputs
  always @(negedge Clock) begin : monitor
    exp_t e;
    if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      if (e.due < cyc) begin
        chk({e.name, "_late"}, 16'(cyc), 16'(e.due));
      end else begin
        chk({e.name, "_sum"},    {8'h00, Sum},  {8'h00, e.s});
        chk({e.name, "_prod"},   {8'h00, Prod}, {8'h00, e.p});
        chk({e.name, "_prod2x"}, Prod2x,        e.p2);
      end
    end
  end

  // drive one vector just after a rising edge and queue its expected result
  task automatic send(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic ea, input logic eb,
                      input logic [7:0] es, input logic [7:0] ep, input logic [15:0] ep2);
    exp_t e;
    @(posedge Clock);
    #1;
    A = a; B = b; EnA = ea; EnB = eb;
    e.name = name; e.s = es; e.p = ep; e.p2 = ep2; e.due = cyc + LAT;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 10) begin
      @(posedge Clock);
      n++;
    end
    chk("drain_queue_empty", 16'(sb_q.size()), 16'h0000);
    sb_q.delete();
  endtask

  task automatic chk_out(input string name, input logic [7:0] es, input logic [7:0] ep,
                         input logic [15:0] ep2);
    chk({name, "_sum"},    {8'h00, Sum},  {8'h00, es});
    chk({name, "_prod"},   {8'h00, Prod}, {8'h00, ep});
    chk({name, "_prod2x"}, Prod2x,        ep2);
  endtask

  initial begin
    nReset = 1'b0;
    A = 8'h00; B = 8'h00; EnA = 1'b0; EnB = 1'b0;
    #2;
    chk_out("reset_state", 8'h00, 8'h00, 16'h0000);

`ifdef MULADD_MULT_OUTREG_EN
    // inputs change while reset held: outputs stay cleared across edges
    A = 8'h05; B = 8'h03; EnA = 1'b1; EnB = 1'b1;
    @(posedge Clock); #1;
    chk_out("held_in_reset", 8'h00, 8'h00, 16'h0000);
    @(negedge Clock);
    nReset = 1'b1;
    #1;
    chk_out("after_release_no_edge", 8'h00, 8'h00, 16'h0000);
    @(posedge Clock); #1;
    chk_out("first_edge_after_release", 8'h08, 8'h0F, 16'h000F);
`else
    // no state: reset low has no effect on the combinational result
    A = 8'h05; B = 8'h03; EnA = 1'b1; EnB = 1'b1;
    #1;
    chk_out("comb_in_reset", 8'h08, 8'h0F, 16'h000F);
    nReset = 1'b1;
`endif

    send("v05x03",  8'h05, 8'h03, 1'b1, 1'b1, 8'h08, 8'h0F, 16'h000F);
    send("v7Fp01",  8'h7F, 8'h01, 1'b1, 1'b1, 8'h80, 8'h7F, 16'h007F);
    send("v80x80",  8'h80, 8'h80, 1'b1, 1'b1, 8'h00, 8'h00, 16'h4000);
    send("v01xFA",  8'h01, 8'hFA, 1'b1, 1'b1, 8'hFB, 8'hFA, 16'hFFFA);
    send("vFDx04",  8'hFD, 8'h04, 1'b1, 1'b1, 8'h01, 8'hF4, 16'hFFF4);
    send("v00x5A",  8'h00, 8'h5A, 1'b1, 1'b1, 8'h5A, 8'h00, 16'h0000);
    send("en00",    8'h22, 8'h11, 1'b0, 1'b0, 8'h00, 8'h42, 16'h0242);
    send("en10",    8'h22, 8'h11, 1'b1, 1'b0, 8'h22, 8'h42, 16'h0242);
    send("en01",    8'h22, 8'h11, 1'b0, 1'b1, 8'h11, 8'h42, 16'h0242);
    send("en11",    8'h22, 8'h11, 1'b1, 1'b1, 8'h33, 8'h42, 16'h0242);
    send("v7Fx7F",  8'h7F, 8'h7F, 1'b1, 1'b1, 8'hFE, 8'h01, 16'h3F01);
    send("v80x7F",  8'h80, 8'h7F, 1'b1, 1'b1, 8'hFF, 8'h80, 16'hC080);
    send("v80x01",  8'h80, 8'h01, 1'b1, 1'b1, 8'h81, 8'h80, 16'hFF80);
    send("vFFxFF",  8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFE, 8'h01, 16'h0001);
    drain();

`ifdef MULADD_MULT_OUTREG_EN
    // new inputs are not visible until the next rising edge
    @(posedge Clock); #1;
    A = 8'h02; B = 8'h03;
    #2;
    chk_out("hold_before_edge", 8'hFE, 8'h01, 16'h0001);
    @(posedge Clock); #1;
    chk_out("after_edge", 8'h05, 8'h06, 16'h0006);
    // asynchronous reset mid-cycle clears at once and holds until release + edge
    #1;
    nReset = 1'b0;
    #1;
    chk_out("async_clear", 8'h00, 8'h00, 16'h0000);
    A = 8'h05; B = 8'h03;
    @(posedge Clock); #1;
    chk_out("clear_held_edge", 8'h00, 8'h00, 16'h0000);
    @(negedge Clock);
    nReset = 1'b1;
    #1;
    chk_out("clear_after_release", 8'h00, 8'h00, 16'h0000);
    @(posedge Clock); #1;
    chk_out("update_after_release", 8'h08, 8'h0F, 16'h000F);
`else
    // reset toggling mid-cycle leaves the combinational outputs alone
    @(posedge Clock); #1;
    A = 8'h02; B = 8'h03;
    #1;
    chk_out("comb_new_inputs", 8'h05, 8'h06, 16'h0006);
    nReset = 1'b0;
    #1;
    chk_out("comb_reset_no_effect", 8'h05, 8'h06, 16'h0006);
    nReset = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muladd_mult.md
MULADD_MULT -- requirements
Module: muladd_mult

Interface
REQ-001 Parameter WIDTH, default 8, data width of A, B, Sum and Prod; Prod2x is 2*WIDTH bits.
REQ-002 Clock  input  1  rising-edge clock, used only when the output register stage is compiled in.
REQ-003 nReset  input  1  asynchronous, active-low reset.
REQ-004 A  input  WIDTH  signed two's-complement operand A.
REQ-005 B  input  WIDTH  signed two's-complement operand B.
REQ-006 EnA  input  1  gates A into the adder; 0 forces the A term to zero.
REQ-007 EnB  input  1  gates B into the adder; 0 forces the B term to zero.
REQ-008 Sum  output  WIDTH  gated sum (EnA?A:0)+(EnB?B:0).
REQ-009 Prod  output  WIDTH  low WIDTH bits of signed A*B.
REQ-010 Prod2x  output  2*WIDTH  full signed product A*B.

Function
REQ-011 Sum is computed modulo 2^WIDTH; overflow wraps, with no saturation and no carry output.
REQ-012 EnA=0 and EnB=0 gives Sum=0; EnA=1 and EnB=0 gives Sum=A; EnA=0 and EnB=1 gives Sum=B.
REQ-013 Prod2x is the exact signed product; for WIDTH=8 its range is -16256..+16384.
REQ-014 Prod equals Prod2x[WIDTH-1:0], so A=1 gives Prod=B and A=0 gives Prod=0.
REQ-015 The product uses signed operands; Prod is identical for signed or unsigned interpretation, but Prod2x is not.
REQ-016 The multiplier is a combinational signed array or Booth structure built from explicit partial products, not a single behavioural operator.
REQ-017 The Sum and product paths are independent; EnA and EnB do not affect Prod or Prod2x.
REQ-018 The default build is purely combinational with zero latency; Clock and nReset have no effect, and tying both to 0 is legal.

Reset
REQ-019 Without the output register stage the block holds no state and nReset has no effect.
REQ-020 With the register stage, nReset low asynchronously clears Sum, Prod and Prod2x to 0.
REQ-021 Outputs hold 0 while nReset is low and update on the first rising Clock edge after nReset goes high.
REQ-022 Asserting reset while a result is pending discards that result.

Configuration
REQ-023 Macro MULADD_MULT_OUTREG_EN enables the output register stage; it is undefined by default.
REQ-024 With MULADD_MULT_OUTREG_EN defined, Sum, Prod and Prod2x are registered on rising Clock, giving 1-cycle latency from the inputs, and reset behaves per REQ-020 to REQ-022.
REQ-025 With MULADD_MULT_OUTREG_EN undefined, the outputs are combinational per REQ-018.
REQ-026 The arithmetic results are identical in both builds; only timing differs.

Verification
REQ-027 A=0x05, B=0x03, EnA=1, EnB=1 -> Sum=0x08, Prod=0x0F, Prod2x=0x000F.
REQ-028 A=0x7F, B=0x01, EnA=1, EnB=1 -> Sum=0x80 (wrap); A=0x80, B=0x80 -> Sum=0x00, Prod2x=0x4000.
REQ-029 A=0x01, B=0xFA -> Prod=0xFA; A=0xFD, B=0x04 -> Prod=0xF4, Prod2x=0xFFF4; A=0x00 -> Prod=0x00.
REQ-030 A=0x22, B=0x11 with EnA/EnB set to 00, 10, 01 and 11 -> Sum=0x00, 0x22, 0x11, 0x33.
REQ-031 OUTREG build: apply A=0x02, B=0x03 -> outputs keep their old values until the next rising edge, then Sum=0x05, Prod=0x06.
REQ-032 OUTREG build: pull nReset low mid-cycle -> all outputs go to 0 immediately without a clock edge and stay 0 until release plus one edge.
